// File: rtl/cp0_tlb_if.sv
// cp0_tlb_if: pipeline/TLB-facing bus of the CP0 register file.
//   master : pipeline side. It drives the mfc0/mtc0, exception, eret, interrupt
//            and tlbp/tlbr inputs and receives the read data and live registers.
//   slave  : the CP0 register file itself.
interface cp0_tlb_if #(
    parameter int TLBNUM  = 16,
    parameter int N_HWINT = 6
);
    localparam int IW = $clog2(TLBNUM);

    logic [4:0]         raddr;
    logic [31:0]        rdata;
    logic               mtc0_we;
    logic [4:0]         mtc0_addr;
    logic [31:0]        mtc0_wdata;
    logic               ex_valid;
    logic [4:0]         ex_code;
    logic [31:0]        ex_pc;
    logic               ex_bd;
    logic [31:0]        ex_badvaddr;
    logic               eret;
    logic [N_HWINT-1:0] hw_int;
    logic               int_req;
    logic [31:0]        epc_out;
    logic [31:0]        status_out;
    logic [31:0]        cause_out;
    logic               tlbp_we;
    logic               tlbp_found;
    logic [IW-1:0]      tlbp_idx;
    logic               tlbr_we;
    logic [31:0]        tlbr_hi;
    logic [31:0]        tlbr_lo0;
    logic [31:0]        tlbr_lo1;
    logic [IW-1:0]      index_out;
    logic [IW-1:0]      random_out;
    logic [31:0]        entryhi_out;
    logic [31:0]        entrylo0_out;
    logic [31:0]        entrylo1_out;

    modport master (
        output raddr, mtc0_we, mtc0_addr, mtc0_wdata,
               ex_valid, ex_code, ex_pc, ex_bd, ex_badvaddr, eret, hw_int,
               tlbp_we, tlbp_found, tlbp_idx, tlbr_we, tlbr_hi, tlbr_lo0, tlbr_lo1,
        input  rdata, int_req, epc_out, status_out, cause_out,
               index_out, random_out, entryhi_out, entrylo0_out, entrylo1_out
    );

    modport slave (
        input  raddr, mtc0_we, mtc0_addr, mtc0_wdata,
               ex_valid, ex_code, ex_pc, ex_bd, ex_badvaddr, eret, hw_int,
               tlbp_we, tlbp_found, tlbp_idx, tlbr_we, tlbr_hi, tlbr_lo0, tlbr_lo1,
        output rdata, int_req, epc_out, status_out, cause_out,
               index_out, random_out, entryhi_out, entrylo0_out, entrylo1_out
    );
endinterface

// File: rtl/cp0_tlb.sv
// cp0_tlb: coprocessor-0 register file (exception state, Count/Compare timer,
// TLB management registers).
//   clk    : clock, all state updates on the rising edge
//   resetn : asynchronous active-low reset
//   bus    : cp0_tlb_if slave. It carries mfc0 read, mtc0 write, exception/eret
//            commit, hw interrupt lines, tlbp/tlbr results, the masked interrupt
//            request and the live register values.
module cp0_tlb #(
    parameter int TLBNUM    = 16,
    parameter int COUNT_DIV = 2,
    parameter int N_HWINT   = 6
) (
    input logic      clk,
    input logic      resetn,
    cp0_tlb_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [IW-1:0] RAND_TOP = IW'(TLBNUM - 1);
    localparam logic [PW-1:0] PRESC_TOP = PW'(COUNT_DIV - 1);

    logic          r_index_p;
    logic [IW-1:0] r_index;
    logic [IW-1:0] r_random;
    logic [IW-1:0] r_wired;
    logic [25:0]   r_lo0, r_lo1;
    logic [31:0]   r_badvaddr;
    logic [31:0]   r_count;
    logic [PW-1:0] r_presc;
    logic [18:0]   r_hi_vpn2;
    logic [7:0]    r_hi_asid;
    logic [31:0]   r_compare;
    logic [7:0]    r_im;
    logic          r_exl, r_ie;
    logic          r_bd, r_ti;
    logic [5:0]    r_ip_hw;
    logic [1:0]    r_ip_sw;
    logic [4:0]    r_exccode;
    logic [31:0]   r_epc;

    // An mtc0 is dropped entirely when an exception commits or when a
    // tlbp/tlbr result is written in the same cycle.
    logic w_mtc0;
    assign w_mtc0 = bus.mtc0_we & ~bus.ex_valid & ~bus.tlbp_we & ~bus.tlbr_we;

    logic w_wr_index, w_wr_lo0, w_wr_lo1, w_wr_wired, w_wr_count, w_wr_hi;
    logic w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc;
    assign w_wr_index   = w_mtc0 && (bus.mtc0_addr == 5'd0);
    assign w_wr_lo0     = w_mtc0 && (bus.mtc0_addr == 5'd2);
    assign w_wr_lo1     = w_mtc0 && (bus.mtc0_addr == 5'd3);
    assign w_wr_wired   = w_mtc0 && (bus.mtc0_addr == 5'd6);
    assign w_wr_count   = w_mtc0 && (bus.mtc0_addr == 5'd9);
    assign w_wr_hi      = w_mtc0 && (bus.mtc0_addr == 5'd10);
    assign w_wr_compare = w_mtc0 && (bus.mtc0_addr == 5'd11);
    assign w_wr_status  = w_mtc0 && (bus.mtc0_addr == 5'd12);
    assign w_wr_cause   = w_mtc0 && (bus.mtc0_addr == 5'd13);
    assign w_wr_epc     = w_mtc0 && (bus.mtc0_addr == 5'd14);

    logic        w_tick;
    logic [31:0] w_count_inc;
    assign w_tick      = (r_presc == PRESC_TOP);
    assign w_count_inc = r_count + 32'd1;

    // Address-error and TLB exceptions capture BadVAddr; only the TLB ones
    // (Mod/TLBL/TLBS) also load EntryHi.VPN2 for the refill handler.
    logic w_ex_addr, w_ex_tlb;
    assign w_ex_addr = (bus.ex_code >= 5'd1) && (bus.ex_code <= 5'd5);
    assign w_ex_tlb  = (bus.ex_code >= 5'd1) && (bus.ex_code <= 5'd3);

    // Next value of Cause.IP[7:2]; the timer shares IP[7] with the top line.
    logic [5:0] w_ip_hw_nxt;
    for (genvar k = 0; k < 6; k++) begin : g_ip
        logic w_line;
        if (k < N_HWINT) begin : g_on
            assign w_line = bus.hw_int[k];
        end else begin : g_off
            assign w_line = 1'b0;
        end
        if (k == 5) begin : g_ti
            assign w_ip_hw_nxt[k] = w_line | r_ti;
        end else begin : g_hw
            assign w_ip_hw_nxt[k] = w_line;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_index_p  <= 1'b0;
            r_index    <= '0;
            r_random   <= RAND_TOP;
            r_wired    <= '0;
            r_lo0      <= '0;
            r_lo1      <= '0;
            r_badvaddr <= '0;
            r_count    <= '0;
            r_presc    <= '0;
            r_hi_vpn2  <= '0;
            r_hi_asid  <= '0;
            r_compare  <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip_hw    <= '0;
            r_ip_sw    <= '0;
            r_exccode  <= '0;
            r_epc      <= '0;
        end else begin
            // Random walks down to Wired, then reloads from the top.
            if (w_wr_wired || (r_random <= r_wired)) r_random <= RAND_TOP;
            else                                     r_random <= r_random - 1'b1;
            if (w_wr_wired) r_wired <= bus.mtc0_wdata[IW-1:0];

            if (w_wr_count) begin
                r_count <= bus.mtc0_wdata;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // Compare write acknowledges the timer and beats a same-cycle match.
            if (w_wr_compare) begin
                r_compare <= bus.mtc0_wdata;
                r_ti      <= 1'b0;
            end else if (!w_wr_count && w_tick && (w_count_inc == r_compare)) begin
                r_ti <= 1'b1;
            end

            r_ip_hw <= w_ip_hw_nxt;

            if (w_wr_index) r_index <= bus.mtc0_wdata[IW-1:0];
            if (w_wr_lo0)   r_lo0   <= bus.mtc0_wdata[25:0];
            if (w_wr_lo1)   r_lo1   <= bus.mtc0_wdata[25:0];
            if (w_wr_hi) begin
                r_hi_vpn2 <= bus.mtc0_wdata[31:13];
                r_hi_asid <= bus.mtc0_wdata[7:0];
            end
            if (w_wr_status) begin
                r_im  <= bus.mtc0_wdata[15:8];
                r_exl <= bus.mtc0_wdata[1];
                r_ie  <= bus.mtc0_wdata[0];
            end
            if (w_wr_cause) r_ip_sw <= bus.mtc0_wdata[9:8];
            if (w_wr_epc)   r_epc   <= bus.mtc0_wdata;

            if (bus.eret) r_exl <= 1'b0;

            // Exception commit overrides eret (assigned later in this block).
            if (bus.ex_valid) begin
                if (!r_exl) begin
                    r_epc <= bus.ex_bd ? (bus.ex_pc - 32'd4) : bus.ex_pc;
                    r_bd  <= bus.ex_bd;
                end
                r_exccode <= bus.ex_code;
                r_exl     <= 1'b1;
                if (w_ex_addr) r_badvaddr <= bus.ex_badvaddr;
                if (w_ex_tlb)  r_hi_vpn2  <= bus.ex_badvaddr[31:13];
            end

            if (bus.tlbp_we) begin
                r_index_p <= ~bus.tlbp_found;
                if (bus.tlbp_found) r_index <= bus.tlbp_idx;
            end
            if (bus.tlbr_we) begin
                r_hi_vpn2 <= bus.tlbr_hi[31:13];
                r_hi_asid <= bus.tlbr_hi[7:0];
                r_lo0     <= bus.tlbr_lo0[25:0];
                r_lo1     <= bus.tlbr_lo1[25:0];
            end
        end
    end

    logic [31:0] w_status, w_cause, w_entryhi;
    logic [7:0]  w_ip;
    assign w_ip      = {r_ip_hw, r_ip_sw};
    assign w_status  = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign w_cause   = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b0};
    assign w_entryhi = {r_hi_vpn2, 5'b0, r_hi_asid};

    always_comb begin
        bus.rdata = '0;
        case (bus.raddr)
            5'd0:  bus.rdata = {r_index_p, {(31-IW){1'b0}}, r_index};
            5'd1:  bus.rdata = {{(32-IW){1'b0}}, r_random};
            5'd2:  bus.rdata = {6'b0, r_lo0};
            5'd3:  bus.rdata = {6'b0, r_lo1};
            5'd6:  bus.rdata = {{(32-IW){1'b0}}, r_wired};
            5'd8:  bus.rdata = r_badvaddr;
            5'd9:  bus.rdata = r_count;
            5'd10: bus.rdata = w_entryhi;
            5'd11: bus.rdata = r_compare;
            5'd12: bus.rdata = w_status;
            5'd13: bus.rdata = w_cause;
            5'd14: bus.rdata = r_epc;
            default: bus.rdata = '0;
        endcase
    end

    assign bus.int_req      = r_ie & ~r_exl & (|(w_ip & r_im));
    assign bus.epc_out      = r_epc;
    assign bus.status_out   = w_status;
    assign bus.cause_out    = w_cause;
    assign bus.index_out    = r_index;
    assign bus.random_out   = r_random;
    assign bus.entryhi_out  = w_entryhi;
    assign bus.entrylo0_out = {6'b0, r_lo0};
    assign bus.entrylo1_out = {6'b0, r_lo1};

    // Bits of the TLB read result that have no storage.
    logic w_unused;
    assign w_unused = ^{bus.tlbr_hi[12:8], bus.tlbr_lo0[31:26], bus.tlbr_lo1[31:26]};
endmodule
